dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer in front of the single-port `DataMemory` (8-bit address, 32-bit data, synchronous write, combinational read). Two requesters share the memory: port 0 is the core load/store unit and port 1 is the debug/loader port. The arbiter grants one request at a time using round-robin, drives the memory for exactly one access cycle, and returns a registered one-cycle response to the granted port. It is the only block allowed to drive `DataMemory` write enable.

---
 rtl/dmem_arbiter_if.sv | 45 ++++
 rtl/dmem_arbiter.sv | 93 +++++++++
 tb/tb_dmem_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Request/response bus for both requester ports plus the DataMemory bus.
// slave: the arbiter side; master: the requesters and memory side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid0;
    logic              req_ready0;
    logic              req_we0;
    logic [ADDR_W-1:0] req_addr0;
    logic [DATA_W-1:0] req_wdata0;
    logic              rsp_valid0;
    logic [DATA_W-1:0] rsp_rdata0;

    logic              req_valid1;
    logic              req_ready1;
    logic              req_we1;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata1;
    logic              rsp_valid1;
    logic [DATA_W-1:0] rsp_rdata1;

    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data;
    logic [DATA_W-1:0] mem_rd_data;

    modport slave (
        input  req_valid0, req_we0, req_addr0, req_wdata0,
        output req_ready0, rsp_valid0, rsp_rdata0,
        input  req_valid1, req_we1, req_addr1, req_wdata1,
        output req_ready1, rsp_valid1, rsp_rdata1,
        output mem_wr_en, mem_addr, mem_wr_data,
        input  mem_rd_data
    );

    modport master (
        output req_valid0, req_we0, req_addr0, req_wdata0,
        input  req_ready0, rsp_valid0, rsp_rdata0,
        output req_valid1, req_we1, req_addr1, req_wdata1,
        input  req_ready1, rsp_valid1, rsp_rdata1,
        input  mem_wr_en, mem_addr, mem_wr_data,
        output mem_rd_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a single-port DataMemory.
// Each granted request takes IDLE -> ACCESS -> RESP: one memory cycle and a
// one-cycle registered response to the owner.
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              op_we_q;
    logic [ADDR_W-1:0] op_addr_q;
    logic [DATA_W-1:0] op_wdata_q;
    logic              owner_q;
    logic              last_gnt_q;
    logic [DATA_W-1:0] rdata_q;

    logic              win0;
    logic              win1;
    logic              hs;

    // Pick the winner: a lone requester wins, a contest goes to the port that was not granted last
    always_comb begin
        win0 = bus.req_valid0 && (!bus.req_valid1 || last_gnt_q);
        win1 = bus.req_valid1 && (!bus.req_valid0 || !last_gnt_q);
        hs   = rst_n && (state_q == IDLE) && (win0 || win1);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: a handshake starts a fixed three-cycle sequence
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = hs ? ACCESS : IDLE;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Op registers, grant history and captured read data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_we_q    <= 1'b0;
            op_addr_q  <= '0;
            op_wdata_q <= '0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;
            rdata_q    <= '0;
        end else begin
            if (hs) begin
                op_we_q    <= win1 ? bus.req_we1    : bus.req_we0;
                op_addr_q  <= win1 ? bus.req_addr1  : bus.req_addr0;
                op_wdata_q <= win1 ? bus.req_wdata1 : bus.req_wdata0;
                owner_q    <= win1;
                last_gnt_q <= win1;
            end
            if (state_q == ACCESS) begin
                rdata_q <= op_we_q ? '0 : bus.mem_rd_data;
            end
        end
    end

    // Outputs: ready only in IDLE (and never during reset), write enable only in ACCESS
    always_comb begin
        bus.req_ready0  = rst_n && (state_q == IDLE) && win0;
        bus.req_ready1  = rst_n && (state_q == IDLE) && win1;
        bus.rsp_valid0  = (state_q == RESP) && !owner_q;
        bus.rsp_valid1  = (state_q == RESP) && owner_q;
        bus.rsp_rdata0  = rdata_q;
        bus.rsp_rdata1  = rdata_q;
        bus.mem_wr_en   = (state_q == ACCESS) && op_we_q;
        bus.mem_addr    = op_addr_q;
        bus.mem_wr_data = op_wdata_q;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_en = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    dmem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [31:0] init_val(int i);
        return 32'h5A5A_0000 ^ (i * 32'h0001_0203);
    endfunction

    // DataMemory model: synchronous write, combinational read
    logic [31:0] mem [256];
    assign bus.mem_rd_data = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        end else if (bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transaction-level reference model
    logic [31:0] ref_mem [256];
    logic        last_w = 1'b1;
    int          next_free = 0;
    int          acc_cyc = -1;
    int          rsp_cyc = -1;
    logic        acc_we = 1'b0;
    logic [7:0]  acc_addr = '0;
    logic [31:0] acc_data = '0;
    logic        rsp_port = 1'b0;
    logic [31:0] rsp_data = '0;

    logic [31:0] last_rsp0 = '0;
    logic [31:0] last_rsp1 = '0;
    int          wen_cnt = 0;
    int          acc_at0 = 0;
    int          acc_at1 = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        acc_cyc   = -1;
        rsp_cyc   = -1;
        next_free = 0;
        last_w    = 1'b1;
    endtask

    // One clock cycle: drive inputs, check every output against the model, advance the model
    task automatic step(input logic v0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                        input logic v1, input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                        output logic got0, output logic got1);
        logic e0, e1;
        @(negedge clk);
        bus.req_valid0 = v0; bus.req_we0 = w0; bus.req_addr0 = a0; bus.req_wdata0 = d0;
        bus.req_valid1 = v1; bus.req_we1 = w1; bus.req_addr1 = a1; bus.req_wdata1 = d1;
        #1;
        e0 = 1'b0;
        e1 = 1'b0;
        if (cyc >= next_free) begin
            e0 = v0 && (!v1 || last_w);
            e1 = v1 && (!v0 || !last_w);
        end
        chk("ready0", bus.req_ready0, e0);
        chk("ready1", bus.req_ready1, e1);
        chk("ready_excl", bus.req_ready0 & bus.req_ready1, 0);
        chk("mem_wr_en", bus.mem_wr_en, (cyc == acc_cyc) ? acc_we : 1'b0);
        if (cyc == acc_cyc) begin
            chk("mem_addr", bus.mem_addr, acc_addr);
            if (acc_we) chk("mem_wdata", bus.mem_wr_data, acc_data);
        end
        chk("rsp_valid0", bus.rsp_valid0, (cyc == rsp_cyc) && !rsp_port);
        chk("rsp_valid1", bus.rsp_valid1, (cyc == rsp_cyc) && rsp_port);
        if (cyc == rsp_cyc) begin
            chk("rsp_rdata", rsp_port ? bus.rsp_rdata1 : bus.rsp_rdata0, rsp_data);
            chk("mem_addr_hold", bus.mem_addr, acc_addr);
        end
        if (bus.rsp_valid0) last_rsp0 = bus.rsp_rdata0;
        if (bus.rsp_valid1) last_rsp1 = bus.rsp_rdata1;
        if (bus.mem_wr_en) wen_cnt++;
        got0 = bus.req_ready0 && v0;
        got1 = bus.req_ready1 && v1;
        if (got0) acc_at0 = cyc;
        if (got1) acc_at1 = cyc;
        if (cyc == acc_cyc) begin
            rsp_data = acc_we ? 32'h0 : ref_mem[acc_addr];
            if (acc_we) ref_mem[acc_addr] = acc_data;
        end
        if (e0 || e1) begin
            acc_cyc   = cyc + 1;
            rsp_cyc   = cyc + 2;
            next_free = cyc + 3;
            rsp_port  = e1;
            last_w    = e1;
            acc_we    = e1 ? w1 : w0;
            acc_addr  = e1 ? a1 : a0;
            acc_data  = e1 ? d1 : d0;
        end
    endtask

    task automatic idle(input int n);
        logic g0, g1;
        for (int i = 0; i < n; i++) step(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0, g0, g1);
    endtask

    // Hold each enabled request until accepted, then let the response drain
    task automatic pair(input logic en0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                        input logic en1, input logic w1, input logic [7:0] a1, input logic [31:0] d1);
        logic p0, p1, g0, g1;
        int n;
        p0 = en0;
        p1 = en1;
        n  = 0;
        while ((p0 || p1) && n < 12) begin
            step(p0, w0, a0, d0, p1, w1, a1, d1, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
            n++;
        end
        chk("pair_accept_timeout", {31'h0, p0 | p1}, 0);
        idle(3);
    endtask

    // Assert reset mid-cycle, check reset output values, then release
    task automatic reset_pulse(input int hold);
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid0 = 1'b1;
        bus.req_valid1 = 1'b1;
        #1;
        chk("rst_ready0", bus.req_ready0, 0);
        chk("rst_ready1", bus.req_ready1, 0);
        chk("rst_rsp_valid0", bus.rsp_valid0, 0);
        chk("rst_rsp_valid1", bus.rsp_valid1, 0);
        chk("rst_rsp_rdata0", bus.rsp_rdata0, 0);
        chk("rst_rsp_rdata1", bus.rsp_rdata1, 0);
        chk("rst_mem_wr_en", bus.mem_wr_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wr_data, 0);
        model_reset();
        repeat (hold) @(negedge clk);
        bus.req_valid0 = 1'b0;
        bus.req_valid1 = 1'b0;
        rst_n = 1'b1;
    endtask

    logic        rv [2];
    logic        rw [2];
    logic [7:0]  ra [2];
    logic [31:0] rd [2];

    function automatic logic [7:0] pick_addr();
        return ($urandom % 2 == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom_range(248, 255));
    endfunction

    initial begin
        logic g0, g1, prev, seen;
        int wen0;
        logic [31:0] keep3;

        bus.req_valid0 = 0; bus.req_we0 = 0; bus.req_addr0 = 0; bus.req_wdata0 = 0;
        bus.req_valid1 = 0; bus.req_we1 = 0; bus.req_addr1 = 0; bus.req_wdata1 = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        @(negedge clk);
        load_en = 1'b0;
        reset_pulse(2);

        // Contest right after reset: port 0 write, port 1 read of the same word
        pair(1, 1, 8'd10, 32'hAAAA5555, 1, 0, 8'd10, 32'h0);
        chk("t2_port0_first", {31'h0, acc_at0 < acc_at1}, 1);
        chk("t2_gap", acc_at1 - acc_at0, 3);
        chk("t2_rd", last_rsp1, 32'hAAAA5555);

        // Port 0 write then read
        wen0 = wen_cnt;
        pair(1, 1, 8'd5, 32'd123, 0, 0, 8'd0, 32'h0);
        chk("t1_wen_once", wen_cnt - wen0, 1);
        chk("t1_wr_rsp", last_rsp0, 0);
        pair(1, 0, 8'd5, 32'h0, 0, 0, 8'd0, 32'h0);
        chk("t1_rd", last_rsp0, 32'd123);

        // Port 1 at the top address
        pair(0, 0, 8'd0, 32'h0, 1, 1, 8'd255, 32'hDEADBEEF);
        pair(0, 0, 8'd0, 32'h0, 1, 0, 8'd255, 32'h0);
        chk("t4_rd_top", last_rsp1, 32'hDEADBEEF);

        // Continuous contention with reads: grants must alternate
        seen = 1'b0;
        prev = 1'b0;
        ra[0] = pick_addr();
        ra[1] = pick_addr();
        for (int i = 0; i < 12; i++) begin
            step(1, 0, ra[0], 32'h0, 1, 0, ra[1], 32'h0, g0, g1);
            if (g0 || g1) begin
                if (seen) chk("t3_alternate", {31'h0, g1}, {31'h0, !prev});
                prev = g1;
                seen = 1'b1;
                if (g0) ra[0] = pick_addr();
                if (g1) ra[1] = pick_addr();
            end
        end
        idle(3);

        // No requests: no writes
        wen0 = wen_cnt;
        idle(20);
        chk("idle_no_wen", wen_cnt - wen0, 0);

        // Randomized traffic; requesters hold payload until ready, may withdraw
        for (int p = 0; p < 2; p++) begin
            rv[p] = 0; rw[p] = 0; ra[p] = 0; rd[p] = 0;
        end
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rv[p]) begin
                    if ($urandom % 3 == 0) begin
                        rv[p] = 1'b1;
                        rw[p] = 1'($urandom % 2);
                        ra[p] = pick_addr();
                        rd[p] = $urandom;
                    end
                end else if ($urandom % 10 == 0) begin
                    rv[p] = 1'b0;
                end
            end
            step(rv[0], rw[0], ra[0], rd[0], rv[1], rw[1], ra[1], rd[1], g0, g1);
            if (g0) rv[0] = 1'b0;
            if (g1) rv[1] = 1'b0;
        end
        idle(4);

        // Reset during ACCESS of a write: the write must not land
        keep3 = ref_mem[3];
        step(1, 1, 8'd3, 32'd77, 0, 0, 8'd0, 32'h0, g0, g1);
        chk("t6_accept", {31'h0, g0}, 1);
        reset_pulse(2);
        pair(1, 0, 8'd3, 32'h0, 0, 0, 8'd0, 32'h0);
        chk("t6_addr3_kept", last_rsp0, keep3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
